pixel_frame_ctrl: RTL and testbench

PIXEL_FRAME_CTRL -- requirements
Module: pixel_frame_ctrl

---
 rtl/pixel_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pixel_frame_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_ctrl.sv
// Pixel array frame sequencer: erase, expose, convert (with ADC ramp), read1, read2,
// with continuous mode, synchronous abort and a completed-frame counter.
module pixel_frame_ctrl #(
  parameter int C_ERASE   = 5,
  parameter int C_READ    = 5,
  parameter int C_CONVERT = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_req,
  input  logic [7:0]  exp_time,
  input  logic        cont,
  input  logic        abort,
  output logic        start_ack,
  output logic        erase,
  output logic        expose,
  output logic        convert,
  output logic        read1,
  output logic        read2,
  output logic [7:0]  adc_count,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_EXPOSE  = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_READ1   = 3'd4;
  localparam logic [2:0] S_READ2   = 3'd5;

  localparam logic [15:0] ERASE_LAST = 16'(C_ERASE - 1);
  localparam logic [15:0] READ_LAST  = 16'(C_READ - 1);
  localparam logic [15:0] CONV_LAST  = 16'(C_CONVERT - 1);

  logic [2:0]  state_r, state_adv_s, state_nxt_s;
  logic [15:0] cnt_r, cnt_adv_s, cnt_nxt_s, exp_len_s;
  logic [7:0]  exp_r, exp_adv_s, exp_nxt_s;
  logic        ack_nxt_s, done_adv_s, done_nxt_s;

  logic        start_ack_r, erase_r, expose_r, convert_r, read1_r, read2_r;
  logic        busy_r, frame_done_r;
  logic [7:0]  adc_count_r;
  logic [15:0] frame_cnt_r;

  // A zero exposure still spends one cycle in EXPOSE.
  assign exp_len_s = (exp_r == 8'd0) ? 16'd1 : {8'd0, exp_r};

  // Next-state, phase counter and exposure latch; abort overrides normal advance.
  always_comb begin
    state_adv_s = state_r;
    cnt_adv_s   = cnt_r + 16'd1;
    exp_adv_s   = exp_r;
    done_adv_s  = 1'b0;
    ack_nxt_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_adv_s = 16'd0;
        if (start_req && !abort) begin
          state_adv_s = S_ERASE;
          exp_adv_s   = exp_time;
          ack_nxt_s   = 1'b1;
        end else begin
          state_adv_s = S_IDLE;
        end
      end
      S_ERASE: begin
        if (cnt_r == ERASE_LAST) begin
          state_adv_s = S_EXPOSE;
          cnt_adv_s   = 16'd0;
        end else begin
          state_adv_s = S_ERASE;
        end
      end
      S_EXPOSE: begin
        if (cnt_r == (exp_len_s - 16'd1)) begin
          state_adv_s = S_CONVERT;
          cnt_adv_s   = 16'd0;
        end else begin
          state_adv_s = S_EXPOSE;
        end
      end
      S_CONVERT: begin
        if (cnt_r == CONV_LAST) begin
          state_adv_s = S_READ1;
          cnt_adv_s   = 16'd0;
        end else begin
          state_adv_s = S_CONVERT;
        end
      end
      S_READ1: begin
        if (cnt_r == READ_LAST) begin
          state_adv_s = S_READ2;
          cnt_adv_s   = 16'd0;
        end else begin
          state_adv_s = S_READ1;
        end
      end
      S_READ2: begin
        if (cnt_r == READ_LAST) begin
          cnt_adv_s  = 16'd0;
          done_adv_s = 1'b1;
          if (cont) begin
            state_adv_s = S_ERASE;
            exp_adv_s   = exp_time;
          end else begin
            state_adv_s = S_IDLE;
          end
        end else begin
          state_adv_s = S_READ2;
        end
      end
      default: begin
        state_adv_s = S_IDLE;
        cnt_adv_s   = 16'd0;
      end
    endcase

    if (abort && (state_r != S_IDLE)) begin
      state_nxt_s = S_IDLE;
      cnt_nxt_s   = 16'd0;
      exp_nxt_s   = exp_r;
      done_nxt_s  = 1'b0;
    end else begin
      state_nxt_s = state_adv_s;
      cnt_nxt_s   = cnt_adv_s;
      exp_nxt_s   = exp_adv_s;
      done_nxt_s  = done_adv_s;
    end
  end

  // State registers plus outputs decoded from the next state, so they align with state_r.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= 16'd0;
      exp_r        <= 8'd0;
      start_ack_r  <= 1'b0;
      erase_r      <= 1'b0;
      expose_r     <= 1'b0;
      convert_r    <= 1'b0;
      read1_r      <= 1'b0;
      read2_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      adc_count_r  <= 8'd0;
      frame_cnt_r  <= 16'd0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      exp_r        <= exp_nxt_s;
      start_ack_r  <= ack_nxt_s;
      erase_r      <= (state_nxt_s == S_ERASE);
      expose_r     <= (state_nxt_s == S_EXPOSE);
      convert_r    <= (state_nxt_s == S_CONVERT);
      read1_r      <= (state_nxt_s == S_READ1);
      read2_r      <= (state_nxt_s == S_READ2);
      busy_r       <= (state_nxt_s != S_IDLE);
      frame_done_r <= done_nxt_s;
      adc_count_r  <= (state_nxt_s == S_CONVERT) ? cnt_nxt_s[7:0] : 8'd0;
      if (done_nxt_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  assign start_ack  = start_ack_r;
  assign erase      = erase_r;
  assign expose     = expose_r;
  assign convert    = convert_r;
  assign read1      = read1_r;
  assign read2      = read2_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign adc_count  = adc_count_r;
  assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Bench for pixel_frame_ctrl: builds a per-cycle expected timeline of each frame
// from the phase lengths and compares every cycle against the DUT.
module tb_pixel_frame_ctrl;

  localparam int C_ERASE   = 5;
  localparam int C_READ    = 5;
  localparam int C_CONVERT = 256;

  logic        clk = 1'b0;
  logic        reset_n, start_req, cont, abort;
  logic [7:0]  exp_time;
  logic        start_ack, erase, expose, convert, read1, read2, busy, frame_done;
  logic [7:0]  adc_count;
  logic [15:0] frame_cnt;

  pixel_frame_ctrl #(.C_ERASE(C_ERASE), .C_READ(C_READ), .C_CONVERT(C_CONVERT)) dut (
    .clk(clk), .reset_n(reset_n), .start_req(start_req), .exp_time(exp_time),
    .cont(cont), .abort(abort), .start_ack(start_ack), .erase(erase), .expose(expose),
    .convert(convert), .read1(read1), .read2(read2), .adc_count(adc_count),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // One entry per clock edge: inputs driven before the edge, outputs expected after it.
  typedef struct {
    logic        st;
    logic        ab;
    logic        ct;
    logic [7:0]  et;
    logic [15:0] vec;
    logic [15:0] cnt;
  } step_t;

  step_t       q[$];
  logic [15:0] mcnt;
  int          errors = 0;
  int          checks = 0;
  int          nstep  = 0;

  function automatic logic [15:0] mk(input logic a, input logic er, input logic ex,
                                     input logic cv, input logic r1, input logic r2,
                                     input logic b, input logic d, input logic [7:0] adc);
    return {a, er, ex, cv, r1, r2, b, d, adc};
  endfunction

  function logic [15:0] outs();
    return {start_ack, erase, expose, convert, read1, read2, busy, frame_done, adc_count};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic st, input logic ab, input logic ct, input logic [7:0] et,
                      input logic [15:0] v);
    step_t s;
    s.st = st; s.ab = ab; s.ct = ct; s.et = et; s.vec = v; s.cnt = mcnt;
    q.push_back(s);
  endtask

  // Whole frame; cont and exp_time are randomised where the DUT must ignore them.
  task automatic push_frame(input int e, input logic ack, input logic done_in,
                            input logic st_in, input logic ct_in);
    int xl;
    xl = (e == 0) ? 1 : e;
    if (done_in) mcnt = mcnt + 16'd1;
    for (int i = 0; i < C_ERASE; i++) begin
      if (i == 0) push(st_in, 1'b0, ct_in, 8'(e), mk(ack, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, done_in, 8'd0));
      else        push(1'b1, 1'b0, 1'($urandom), 8'($urandom), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    end
    for (int i = 0; i < xl; i++)
      push(1'b1, 1'b0, 1'($urandom), 8'($urandom), mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    for (int i = 0; i < C_CONVERT; i++)
      push(1'b1, 1'b0, 1'($urandom), 8'($urandom), mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'(i)));
    for (int i = 0; i < C_READ; i++)
      push(1'b1, 1'b0, 1'($urandom), 8'($urandom), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0));
    for (int i = 0; i < C_READ; i++)
      push(1'b1, 1'b0, 1'($urandom), 8'($urandom), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0));
  endtask

  task automatic push_idle(input logic done_in, input logic st, input logic ab, input logic ct);
    if (done_in) mcnt = mcnt + 16'd1;
    push(st, ab, ct, 8'($urandom), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, done_in, 8'd0));
  endtask

  task automatic run_q();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      start_req = s.st; abort = s.ab; cont = s.ct; exp_time = s.et;
      @(posedge clk);
      #1;
      check($sformatf("step%0d outputs", nstep), outs(), s.vec);
      check($sformatf("step%0d frame_cnt", nstep), frame_cnt, s.cnt);
      nstep++;
    end
  endtask

  initial begin
    int e, xl, base;
    mcnt      = 16'd0;
    reset_n   = 1'b0;
    start_req = 1'b1;
    cont      = 1'b0;
    abort     = 1'b0;
    exp_time  = 8'd77;
    #2;
    check("reset outputs", outs(), 16'h0000);
    check("reset frame_cnt", frame_cnt, 16'h0000);
    #11 reset_n = 1'b1;
    start_req = 1'b0;

    // Reference frame, exp_time=10, request held while busy.
    push_idle(1'b0, 1'b0, 1'b0, 1'b0);
    push_frame(10, 1'b1, 1'b0, 1'b1, 1'b0);
    push_idle(1'b1, 1'b0, 1'b0, 1'b0);
    run_q();
    check("frame_cnt after first frame", frame_cnt, 16'd1);

    // Zero exposure, then randomised exposures.
    push_frame(0, 1'b1, 1'b0, 1'b1, 1'b0);
    push_idle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push_frame(int'($urandom_range(1, 60)), 1'b1, 1'b0, 1'b1, 1'b0);
      push_idle(1'b1, 1'b0, 1'b0, 1'b0);
    end
    run_q();

    // Abort beats start in IDLE; abort in convert at adc_count=100; new request after.
    push_idle(1'b0, 1'b1, 1'b1, 1'b0);
    e = int'($urandom_range(0, 30));
    xl = (e == 0) ? 1 : e;
    base = q.size();
    push_frame(e, 1'b1, 1'b0, 1'b1, 1'b0);
    q = q[0 : base + C_ERASE + xl + 100];
    push_idle(1'b0, 1'b1, 1'b1, 1'b1);
    push_idle(1'b0, 1'b0, 1'b1, 1'b0);
    push_idle(1'b0, 1'b0, 1'b0, 1'b0);
    push_frame(int'($urandom_range(1, 20)), 1'b1, 1'b0, 1'b1, 1'b0);
    push_idle(1'b1, 1'b0, 1'b0, 1'b0);
    run_q();

    // Continuous mode: three back-to-back frames, one ack.
    push_frame(4, 1'b1, 1'b0, 1'b1, 1'b0);
    push_frame(4, 1'b0, 1'b1, 1'b1, 1'b1);
    push_frame(4, 1'b0, 1'b1, 1'b1, 1'b1);
    push_idle(1'b1, 1'b0, 1'b0, 1'b0);
    run_q();

    // Abort in last READ2 cycle with cont=1 wins over completion.
    push_frame(int'($urandom_range(1, 20)), 1'b1, 1'b0, 1'b1, 1'b0);
    push_idle(1'b0, 1'b1, 1'b1, 1'b1);
    push_idle(1'b0, 1'b0, 1'b0, 1'b0);
    run_q();

    // frame_cnt wrap.
    @(negedge clk);
    force dut.frame_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_r;
    mcnt = 16'hFFFF;
    #1;
    check("frame_cnt preload", frame_cnt, 16'hFFFF);
    push_frame(int'($urandom_range(1, 20)), 1'b1, 1'b0, 1'b1, 1'b0);
    push_idle(1'b1, 1'b0, 1'b0, 1'b0);
    run_q();
    check("frame_cnt wrap", frame_cnt, 16'h0000);

    // Asynchronous reset during expose; request held through reset is acked after release.
    base = q.size();
    push_frame(int'($urandom_range(5, 30)), 1'b1, 1'b0, 1'b1, 1'b0);
    q = q[0 : base + C_ERASE + 1];
    run_q();
    check("expose before reset", outs(), mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    #3 reset_n = 1'b0;
    start_req = 1'b1;
    #1;
    check("async reset outputs", outs(), 16'h0000);
    check("async reset frame_cnt", frame_cnt, 16'h0000);
    mcnt = 16'd0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    push_frame(int'($urandom_range(0, 20)), 1'b1, 1'b0, 1'b1, 1'b0);
    push_idle(1'b1, 1'b0, 1'b0, 1'b0);
    run_q();
    check("frame_cnt after reset frame", frame_cnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
